// File: rtl/nonce_search_pkg.sv
// nonce_search_pkg: state encoding and FIFO sizing rule shared by the nonce search controller
package nonce_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nonce_search_ctrl_fifo.sv
// nonce_fifo: synchronous FIFO of in-flight nonces; DEPTH must be a power of two
module nonce_fifo import nonce_search_pkg::*; #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int AW = fifo_aw(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    // a pop frees the slot a same-cycle push needs when full
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: sweeps nonces through a pipelined hash core and reports the first winner.
// Define NONCE_SEARCH_PERF_EN to add the perf_cycles / perf_hashes counters.
module nonce_search_ctrl import nonce_search_pkg::*; #(
    parameter int BLOCK_W  = 96,
    parameter int NONCE_W  = 32,
    parameter int HASH_W   = 24,
    parameter int TARGET_W = 8,
    parameter int MAX_OUT  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BLOCK_W-1:0]         block,
    input  logic [TARGET_W-1:0]        target,
    output logic                       hreq_valid,
    input  logic                       hreq_ready,
    output logic [BLOCK_W+NONCE_W-1:0] hreq_data,
    input  logic                       hresp_valid,
    input  logic [HASH_W-1:0]          hresp_hash,
    output logic                       terminado,
    output logic                       found,
    output logic [NONCE_W-1:0]         nonce,
    output logic [1:0]                 state,
`ifdef NONCE_SEARCH_PERF_EN
    output logic [31:0]                perf_cycles,
    output logic [NONCE_W:0]           perf_hashes,
`endif
    output logic                       proto_err
);

    localparam int AW = fifo_aw(MAX_OUT);

    state_t               st, st_nx;
    logic [BLOCK_W-1:0]   blk;
    logic [TARGET_W-1:0]  tgt;
    logic [NONCE_W-1:0]   next_nonce, head;
    logic                 exhausted, full, empty, hs, pop_ok, hit, go;
    logic [AW:0]          count, cnt_nx;
    logic                 unused_hash;

    assign unused_hash = ^hresp_hash[HASH_W-TARGET_W-1:0];

    nonce_fifo #(.W(NONCE_W), .DEPTH(MAX_OUT)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs),
        .din   (next_nonce),
        .pop   (pop_ok),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign go         = st == IDLE && start;
    assign hreq_valid = st == SEARCH && !full && !exhausted;
    assign hreq_data  = {next_nonce, blk};
    assign hs         = hreq_valid && hreq_ready;
    assign pop_ok     = hresp_valid && !empty;
    assign hit        = pop_ok && (hresp_hash[HASH_W-1 -: TARGET_W] < tgt);
    assign cnt_nx     = count + (AW+1)'(hs) - (AW+1)'(pop_ok);
    assign terminado  = st == DONE;
    assign state      = st;

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:   st_nx = start ? SEARCH : IDLE;
            SEARCH: st_nx = hit ? ((cnt_nx == '0) ? DONE : DRAIN)
                          : (exhausted && cnt_nx == '0) ? DONE : SEARCH;
            DRAIN:  st_nx = (cnt_nx == '0) ? DONE : DRAIN;
            DONE:   st_nx = start ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            blk        <= '0;
            tgt        <= '0;
            next_nonce <= '0;
            exhausted  <= 1'b0;
            found      <= 1'b0;
            nonce      <= '0;
            proto_err  <= 1'b0;
        end else begin
            st <= st_nx;
            if (hresp_valid && empty) proto_err <= 1'b1;
            if (go) begin
                blk        <= block;
                tgt        <= target;
                next_nonce <= '0;
                exhausted  <= 1'b0;
                found      <= 1'b0;
            end
            // the wrap to 0 after the last nonce is never issued because exhausted blocks hreq_valid
            if (hs) begin
                next_nonce <= next_nonce + 1'b1;
                nonce      <= next_nonce;
                exhausted  <= &next_nonce;
            end
            if (st == SEARCH && hit) begin
                found <= 1'b1;
                nonce <= head;
            end
        end
    end

`ifdef NONCE_SEARCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_hashes <= '0;
        end else if (go) begin
            perf_cycles <= '0;
            perf_hashes <= '0;
        end else begin
            if ((st == SEARCH || st == DRAIN) && !(&perf_cycles)) perf_cycles <= perf_cycles + 1'b1;
            if (hs) perf_hashes <= perf_hashes + 1'b1;
        end
    end
`endif

endmodule
